// File: rtl/tdm_rx.sv
// TDM receive deserializer: hunts for frame sync, shifts the single-wire
// bitstream MSB first into WIDTH-bit slot words, tags each word with its slot
// index and flags early, late or missing frame syncs.
module tdm_rx #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SLOTS  = 8,
  parameter int unsigned SLOT_W = 3
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              ibit_en,
  input  logic              idata,
  input  logic              ifsync,
  output logic [WIDTH-1:0]  odata,
  output logic              odata_en,
  output logic [SLOT_W-1:0] oslot,
  output logic              olock,
  output logic              oerr
);

  localparam int unsigned       CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0]   LastBit  = CntW'(WIDTH - 1);
  localparam logic [SLOT_W-1:0] LastSlot = SLOT_W'(SLOTS - 1);

  typedef enum logic {StHunt, StRecv} state_e;

  state_e            state_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [SLOT_W-1:0] slot_cnt_q;
  // Only WIDTH-1 bits are held; the LSB is taken straight from idata when the
  // word completes. A newly started word's first bit sits at bit 0 here and
  // reaches the MSB of odata after the remaining WIDTH-1 shifts.
  logic [WIDTH-2:0]  shift_q;

  logic frame_start;
  assign frame_start = (bit_cnt_q == '0) && (slot_cnt_q == '0);

  // Lock indication is a direct copy of the registered FSM state.
  assign olock = (state_q == StRecv);

  // Alignment FSM, bit/slot counters, shifter and registered output pulses.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q    <= StHunt;
      bit_cnt_q  <= '0;
      slot_cnt_q <= '0;
      shift_q    <= '0;
      odata      <= '0;
      odata_en   <= 1'b0;
      oslot      <= '0;
      oerr       <= 1'b0;
    end else begin
      odata_en <= 1'b0;
      oerr     <= 1'b0;
      if (ibit_en) begin
        case (state_q)
          StHunt: begin
            if (ifsync) begin
              shift_q    <= {{(WIDTH-2){1'b0}}, idata};
              bit_cnt_q  <= CntW'(1);
              slot_cnt_q <= '0;
              state_q    <= StRecv;
            end
          end
          StRecv: begin
            if (ifsync && !frame_start) begin
              // Early/late sync: drop the partial word and realign on this bit.
              oerr       <= 1'b1;
              shift_q    <= {{(WIDTH-2){1'b0}}, idata};
              bit_cnt_q  <= CntW'(1);
              slot_cnt_q <= '0;
            end else if (!ifsync && frame_start) begin
              // Missing sync: this bit is discarded and alignment is lost.
              oerr       <= 1'b1;
              bit_cnt_q  <= '0;
              slot_cnt_q <= '0;
              state_q    <= StHunt;
            end else if (bit_cnt_q == LastBit) begin
              odata      <= {shift_q, idata};
              oslot      <= slot_cnt_q;
              odata_en   <= 1'b1;
              bit_cnt_q  <= '0;
              slot_cnt_q <= (slot_cnt_q == LastSlot) ? '0 : slot_cnt_q + SLOT_W'(1);
            end else begin
              shift_q   <= {shift_q[WIDTH-3:0], idata};
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_rx.sv
// Scoreboard bench for tdm_rx: the driver runs a frame-position model and
// queues expected pulses and lock levels; a negedge monitor checks them.
module tb_tdm_rx;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned SLOTS      = 8;
  localparam int unsigned SLOT_W     = 3;
  localparam int          FRAME_BITS = WIDTH * SLOTS;

  logic              iclk = 1'b0;
  logic              irst;
  logic              ibit_en;
  logic              idata;
  logic              ifsync;
  logic [WIDTH-1:0]  odata;
  logic              odata_en;
  logic [SLOT_W-1:0] oslot;
  logic              olock;
  logic              oerr;

  tdm_rx #(
    .WIDTH (WIDTH),
    .SLOTS (SLOTS),
    .SLOT_W(SLOT_W)
  ) dut (
    .iclk    (iclk),
    .irst    (irst),
    .ibit_en (ibit_en),
    .idata   (idata),
    .ifsync  (ifsync),
    .odata   (odata),
    .odata_en(odata_en),
    .oslot   (oslot),
    .olock   (olock),
    .oerr    (oerr)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int                due;
    bit                is_err;
    logic [WIDTH-1:0]  data;
    logic [SLOT_W-1:0] slot;
  } ev_t;

  typedef struct {
    int due;
    bit lock;
    bit rst;
  } cy_t;

  ev_t evq[$];
  cy_t cyq[$];
  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;
  int  gap   = 0;

  // Reference model: locked flag, absolute bit position within the frame and
  // the word assembled so far.
  bit               m_lock;
  int               m_pos;
  logic [WIDTH-1:0] m_word;

  always @(posedge iclk) cyc <= cyc + 1;

  task automatic push_word(input logic [WIDTH-1:0] w, input int slot);
    ev_t e;
    e.due    = cyc + 1;
    e.is_err = 1'b0;
    e.data   = w;
    e.slot   = SLOT_W'(slot);
    evq.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.due    = cyc + 1;
    e.is_err = 1'b1;
    e.data   = '0;
    e.slot   = '0;
    evq.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit en, input bit d, input bit fs);
    cy_t c;
    int  b;
    irst    = rst;
    ibit_en = en;
    idata   = d;
    ifsync  = fs;
    if (rst) begin
      m_lock = 1'b0;
      m_pos  = 0;
      m_word = '0;
    end else if (en) begin
      if (!m_lock) begin
        if (fs) begin
          m_lock            = 1'b1;
          m_word            = '0;
          m_word[WIDTH-1]   = d;
          m_pos             = 1;
        end
      end else if (fs && m_pos != 0) begin
        push_err();
        m_word          = '0;
        m_word[WIDTH-1] = d;
        m_pos           = 1;
      end else if (!fs && m_pos == 0) begin
        push_err();
        m_lock = 1'b0;
      end else begin
        b = m_pos % WIDTH;
        if (b == 0) m_word = '0;
        m_word[WIDTH-1-b] = d;
        if (b == WIDTH - 1) push_word(m_word, m_pos / WIDTH);
        m_pos = (m_pos + 1) % FRAME_BITS;
      end
    end
    c.due  = cyc + 1;
    c.lock = m_lock;
    c.rst  = rst;
    cyq.push_back(c);
    @(posedge iclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'($urandom), 1'($urandom));
  endtask

  // Sends the first nbits of one frame; mode picks the slot word contents.
  task automatic send_frame(input int mode, input bit sync, input int nbits);
    logic [WIDTH-1:0] w;
    int               b;
    int               k;
    w = '0;
    for (int i = 0; i < nbits; i++) begin
      b = i % WIDTH;
      k = i / WIDTH;
      if (b == 0) begin
        case (mode)
          0:       w = 32'hA5A5_0000 + WIDTH'(k);
          1:       w = $urandom;
          2:       w = 32'hFFFF_FFFF;
          default: w = 32'hAAAA_AAAA;
        endcase
      end
      for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'($urandom), 1'($urandom));
      drive(1'b0, 1'b1, w[WIDTH-1-b], sync && (i == 0));
    end
  endtask

  // Monitor: per-cycle lock/reset checks and pulse scoreboard.
  always @(negedge iclk) begin : monitor
    cy_t c;
    ev_t e;
    if (cyq.size() > 0 && cyq[0].due == cyc) begin
      c = cyq.pop_front();
      tests++;
      if (olock !== c.lock) begin
        fails++;
        $display("FAIL olock cyc=%0d got %b want %b", cyc, olock, c.lock);
      end
      if (c.rst) begin
        tests++;
        if (odata !== '0 || oslot !== '0 || odata_en !== 1'b0 || oerr !== 1'b0) begin
          fails++;
          $display("FAIL reset_outputs cyc=%0d got data=%h slot=%0d en=%b err=%b want all 0",
                   cyc, odata, oslot, odata_en, oerr);
        end
      end
    end
    if (evq.size() > 0 && evq[0].due < cyc) begin
      e = evq.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_pulse due=%0d err=%b data=%h slot=%0d got nothing",
               e.due, e.is_err, e.data, e.slot);
    end
    if (odata_en === 1'b1 || oerr === 1'b1) begin
      tests++;
      if (evq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse cyc=%0d got en=%b err=%b data=%h slot=%0d want none",
                 cyc, odata_en, oerr, odata, oslot);
      end else begin
        e = evq.pop_front();
        if (e.due != cyc || oerr !== e.is_err || odata_en !== !e.is_err ||
            (!e.is_err && (odata !== e.data || oslot !== e.slot))) begin
          fails++;
          $display("FAIL pulse cyc=%0d got en=%b err=%b data=%h slot=%0d want due=%0d err=%b data=%h slot=%0d",
                   cyc, odata_en, oerr, odata, oslot, e.due, e.is_err, e.data, e.slot);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int r;
    m_lock = 1'b0;
    m_pos  = 0;
    m_word = '0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    idle(2);

    // Two aligned frames, strobe every cycle.
    send_frame(0, 1'b1, FRAME_BITS);
    send_frame(0, 1'b1, FRAME_BITS);
    idle(3);

    // Strobe one cycle in four.
    gap = 3;
    send_frame(0, 1'b1, FRAME_BITS);
    send_frame(0, 1'b1, FRAME_BITS);
    gap = 0;

    // Early sync at slot 3, bit 4 of the second frame.
    send_frame(0, 1'b1, FRAME_BITS);
    send_frame(0, 1'b1, 100);
    send_frame(0, 1'b1, FRAME_BITS);

    // Missing sync, then relock.
    send_frame(0, 1'b0, FRAME_BITS);
    send_frame(0, 1'b1, FRAME_BITS);

    // Reset at slot 5, bit 17; unsynced bits afterwards must be ignored.
    send_frame(1, 1'b1, 5 * WIDTH + 17);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(1, 1'b0, 50);
    send_frame(1, 1'b1, FRAME_BITS);

    // Constant-one and alternating patterns.
    send_frame(2, 1'b1, FRAME_BITS);
    send_frame(3, 1'b1, FRAME_BITS);

    // Random mix of gaps, dropped syncs and early syncs.
    for (int n = 0; n < 8; n++) begin
      gap = $urandom_range(0, 2);
      r   = $urandom_range(0, 9);
      if (r == 0)      send_frame(1, 1'b0, FRAME_BITS);
      else if (r == 1) send_frame(1, 1'b1, $urandom_range(1, FRAME_BITS - 1));
      else             send_frame(1, 1'b1, FRAME_BITS);
    end
    gap = 0;
    idle(6);

    tests++;
    if (evq.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending pulses want 0", evq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
